// File: rtl/c432_key_loader_pkg.sv
// Shared state encoding and default key constants for the c432 key loader.
package c432_key_pkg;
  localparam int KEY_W_DEF = 20;
  localparam logic [KEY_W_DEF-1:0] DECOY_DEF = 20'h00000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ARMED,
    ERROR,
    LOCKOUT
  } state_t;
endpackage

// File: rtl/c432_key_loader_if.sv
// Serial key-store link: one data bit per valid/ready beat.
interface c432_key_loader_if;
  logic sdi;
  logic sdi_valid;
  logic sdi_ready;

  modport master (output sdi, output sdi_valid, input sdi_ready);
  modport slave  (input sdi, input sdi_valid, output sdi_ready);
endinterface

// File: rtl/c432_key_loader_timer.sv
// Inactivity counter for LOAD; expired flags TIMEOUT_CYC-1 idle cycles since the last clear.
module c432_key_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic CK,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] timer;

  assign expired = (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && !expired) begin
      timer <= timer + 1'b1;
    end
  end
endmodule

// File: rtl/c432_key_loader.sv
// Loads the 20-bit c432 unlock key serially, checks even parity, and drives p1..p20.
// state   | meaning
// IDLE    | waiting for start, decoy driven
// LOAD    | shifting key bits, then parity bit
// CHECK   | one-cycle parity verdict
// ARMED   | verified key on key_out, sticky until reset
// ERROR   | load failed, retry allowed via start
// LOCKOUT | retry budget spent, only reset leaves
module c432_key_loader
  import c432_key_pkg::*;
#(
  parameter int                  KEY_W       = KEY_W_DEF,
  parameter logic [KEY_W-1:0]    DECOY       = DECOY_DEF,
  parameter int                  TIMEOUT_CYC = 64,
  parameter int                  MAX_RETRY   = 3
) (
  input  logic               CK,
  input  logic               RST_N,
  input  logic               start,
  c432_key_loader_if.slave   ks,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               busy,
  output logic               err,
  output logic               locked_out
);
  localparam int CW = $clog2(KEY_W + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [KEY_W-1:0]  shreg;
  logic              par;
  logic [RW-1:0]     retry;
  logic [RW-1:0]     retry_inc;
  logic              rdy;
  logic              beat;
  logic              expired;

  assign ks.sdi_ready = rdy;
  assign beat         = ks.sdi_valid & rdy;
  assign retry_inc    = (retry == RW'(MAX_RETRY)) ? retry : retry + 1'b1;

  c432_key_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .CK      (CK),
    .RST_N   (RST_N),
    .clear   ((state != LOAD) | beat),
    .enable  (state == LOAD),
    .expired (expired)
  );

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      retry      <= '0;
      rdy        <= 1'b0;
      key_out    <= DECOY;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
            shreg <= '0;
            rdy   <= 1'b1;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        LOAD: begin
          if (beat) begin
            if (cnt < CW'(KEY_W)) begin
              shreg[cnt] <= ks.sdi;
              cnt        <= cnt + 1'b1;
            end else begin
              par   <= ks.sdi;
              state <= CHECK;
              rdy   <= 1'b0;
            end
          end else if (expired) begin
            rdy   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b1;
            retry <= retry_inc;
            if (retry_inc == RW'(MAX_RETRY)) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state <= ERROR;
            end
          end
        end
        CHECK: begin
          busy <= 1'b0;
          if ((^shreg ^ par) == 1'b0) begin
            // The only path by which loaded bits ever reach the c432 inputs.
            state     <= ARMED;
            key_out   <= shreg;
            key_valid <= 1'b1;
          end else begin
            err   <= 1'b1;
            retry <= retry_inc;
            if (retry_inc == RW'(MAX_RETRY)) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state <= ERROR;
            end
          end
        end
        ARMED: begin
          state <= ARMED;
        end
        LOCKOUT: begin
          state <= LOCKOUT;
        end
        default: begin
          state     <= IDLE;
          rdy       <= 1'b0;
          busy      <= 1'b0;
          key_out   <= DECOY;
          key_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: vector table, corner sequences, randomized loads vs. model.
module tb_c432_key_loader;
  logic        CK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [19:0] key_out;
  logic        key_valid, busy, err, locked_out;

  int tests = 0;
  int fails = 0;
  int gap_arr [21];

  c432_key_loader_if kif ();

  c432_key_loader dut (
    .CK         (CK),
    .RST_N      (RST_N),
    .start      (start),
    .ks         (kif.slave),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err),
    .locked_out (locked_out)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [19:0] key;
    logic        par;
    logic        exp_kv;
    logic [19:0] exp_ko;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    start = 1'b0;
    kif.sdi = 1'b0;
    kif.sdi_valid = 1'b0;
    for (int i = 0; i < 21; i++) gap_arr[i] = 0;
    repeat (2) step();
    RST_N = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic b, input int gap);
    kif.sdi_valid = 1'b0;
    repeat (gap) step();
    kif.sdi_valid = 1'b1;
    kif.sdi = b;
    step();
    kif.sdi_valid = 1'b0;
  endtask

  task automatic load(input logic [19:0] key, input logic p);
    for (int i = 0; i < 20; i++) beat(key[i], gap_arr[i]);
    beat(p, gap_arr[20]);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{key: 20'hA5C3E, par: 1'b1, exp_kv: 1'b1, exp_ko: 20'hA5C3E, exp_err: 1'b0};
    vecs[1] = '{key: 20'hA5C3E, par: 1'b0, exp_kv: 1'b0, exp_ko: 20'h00000, exp_err: 1'b1};
    vecs[2] = '{key: 20'hFFFFF, par: 1'b0, exp_kv: 1'b1, exp_ko: 20'hFFFFF, exp_err: 1'b0};
    vecs[3] = '{key: 20'hFFFFF, par: 1'b1, exp_kv: 1'b0, exp_ko: 20'h00000, exp_err: 1'b1};
    vecs[4] = '{key: 20'h00001, par: 1'b1, exp_kv: 1'b1, exp_ko: 20'h00001, exp_err: 1'b0};
    vecs[5] = '{key: 20'h00000, par: 1'b0, exp_kv: 1'b1, exp_ko: 20'h00000, exp_err: 1'b0};
    vecs[6] = '{key: 20'h80000, par: 1'b0, exp_kv: 1'b0, exp_ko: 20'h00000, exp_err: 1'b1};

    // Reset values
    RST_N = 1'b0;
    kif.sdi = 1'b0;
    kif.sdi_valid = 1'b0;
    #3;
    chk("rst_key_out", key_out, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_sdi_ready", kif.sdi_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_locked", locked_out, 0);

    // Vector table: single load each, with the CHECK-cycle latency probe
    foreach (vecs[v]) begin
      do_reset();
      pulse_start();
      chk("tbl_ready_in_load", kif.sdi_ready, 1);
      load(vecs[v].key, vecs[v].par);
      chk("tbl_check_busy", busy, 1);
      chk("tbl_check_kv", key_valid, 0);
      chk("tbl_check_ready", kif.sdi_ready, 0);
      step();
      chk("tbl_kv", key_valid, vecs[v].exp_kv);
      chk("tbl_ko", key_out, vecs[v].exp_ko);
      chk("tbl_err", err, vecs[v].exp_err);
      chk("tbl_busy_done", busy, 0);
    end

    // Bad parity, then a retry that arms
    do_reset();
    pulse_start();
    load(20'hA5C3E, 1'b0);
    step();
    chk("retry_err_set", err, 1);
    pulse_start();
    chk("retry_err_clear", err, 0);
    chk("retry_ready", kif.sdi_ready, 1);
    load(20'hA5C3E, 1'b1);
    step();
    chk("retry_kv", key_valid, 1);
    chk("retry_ko", key_out, 20'hA5C3E);

    // Timeout after 5 bits: ERROR exactly on the 64th idle edge
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) beat(1'b1, 0);
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 63) begin
        chk("to_ready_63", kif.sdi_ready, 1);
        chk("to_err_63", err, 0);
      end
    end
    chk("to_err_64", err, 1);
    chk("to_ready_64", kif.sdi_ready, 0);
    chk("to_busy_64", busy, 0);

    // Three bad loads lock out; further starts are ignored
    do_reset();
    for (int n = 0; n < 3; n++) begin
      pulse_start();
      load(20'hA5C3E, 1'b0);
      step();
      chk("lk_err", err, 1);
      chk("lk_locked", locked_out, (n == 2) ? 1 : 0);
    end
    pulse_start();
    chk("lk_ready_after_start", kif.sdi_ready, 0);
    chk("lk_busy_after_start", busy, 0);
    load(20'hA5C3E, 1'b1);
    step();
    chk("lk_ko", key_out, 0);
    chk("lk_kv", key_valid, 0);
    chk("lk_still_locked", locked_out, 1);
    do_reset();
    chk("lk_reset_clears", locked_out, 0);

    // Asynchronous reset in the middle of a load
    do_reset();
    pulse_start();
    for (int i = 0; i < 12; i++) beat(1'b1, 0);
    chk("mid_busy_before", busy, 1);
    RST_N = 1'b0;
    #2;
    chk("mid_busy", busy, 0);
    chk("mid_ready", kif.sdi_ready, 0);
    chk("mid_ko", key_out, 0);
    chk("mid_kv", key_valid, 0);
    chk("mid_err", err, 0);
    @(posedge CK);
    #1;
    RST_N = 1'b1;
    pulse_start();
    load(20'hA5C3E, 1'b1);
    step();
    chk("mid_reload_kv", key_valid, 1);
    chk("mid_reload_ko", key_out, 20'hA5C3E);

    // ARMED is sticky against start and sdi traffic
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      kif.sdi_valid = 1'b1;
      kif.sdi = i[0];
      step();
      start = 1'b0;
      chk("arm_ko", key_out, 20'hA5C3E);
      chk("arm_kv", key_valid, 1);
      chk("arm_ready", kif.sdi_ready, 0);
    end
    kif.sdi_valid = 1'b0;

    // Randomized loads against a behavioural model
    for (int it = 0; it < 30; it++) begin
      int          nfail;
      bit          armed, locked, good, timed_out;
      logic [19:0] armed_key, key;
      logic        p;
      int          nl;
      do_reset();
      nfail = 0;
      armed = 0;
      locked = 0;
      armed_key = '0;
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        key = 20'($urandom);
        good = ($urandom_range(0, 3) == 0);
        p = good ? ($countones(key) % 2 == 1) : ($countones(key) % 2 == 0);
        for (int i = 0; i < 21; i++)
          gap_arr[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
        if ($urandom_range(0, 5) == 0)
          gap_arr[$urandom_range(0, 20)] = $urandom_range(63, 64);
        timed_out = 0;
        for (int i = 0; i < 21; i++) if (gap_arr[i] >= 64) timed_out = 1;
        pulse_start();
        load(key, p);
        step();
        if (!armed && !locked) begin
          if (good && !timed_out) begin
            armed = 1;
            armed_key = key;
          end else begin
            nfail++;
            if (nfail >= 3) locked = 1;
          end
        end
        chk("rnd_kv", key_valid, armed);
        chk("rnd_ko", key_out, armed ? armed_key : 20'h00000);
        chk("rnd_err", err, (!armed && nfail > 0) ? 1 : 0);
        chk("rnd_locked", locked_out, locked);
        chk("rnd_ready", kif.sdi_ready, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
